wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter for the out-of-order core. It shares the single ROB writeback/update port among the three functional units: ALU, LSU and MUL. Each unit pushes completed results (value plus ROB index) into a small per-source queue. A round-robin arbiter drains the queues into one registered broadcast bus that feeds the ROB update port and wakes up reservation-station operands.

## Interface
Parameters:
- DATA_W, 32, result value width
- ROB_IDX_W, 5, ROB index width
- DEPTH, 2, entries per source queue; power of two, ≥2

Ports:
- clk_i  in  1  core clock
- reset_i  in  1  synchronous, active-high reset
- flush_i  in  1  pipeline flush; discards all queued and pending results
- alu_valid_i  in  1  ALU result valid
- alu_value_i  in  DATA_W  ALU result
- alu_rob_idx_i  in  ROB_IDX_W  ALU result ROB index
- alu_ready_o  out  1  ALU queue can accept
- lsu_valid_i / lsu_value_i / lsu_rob_idx_i / lsu_ready_o  same widths, LSU source
- mul_valid_i / mul_value_i / mul_rob_idx_i / mul_ready_o  same widths, MUL source
- wb_valid_o  out  1  broadcast result valid
- wb_value_o  out  DATA_W  broadcast value
- wb_rob_idx_o  out  ROB_IDX_W  broadcast ROB index
- wb_src_o  out  2  granted source: 0 ALU, 1 LSU, 2 MUL
- wb_ready_i  in  1  ROB accepts the broadcast this cycle
- pending_o  out  3  per-source queue non-empty, bit order {MUL, LSU, ALU}

## Operation
- **Push:** a source result is written to its queue on an edge where `x_valid_i && x_ready_o`.
- **Ready:** `x_ready_o = (count_x < DEPTH) && !flush_i`. It is derived from registered occupancy only, so there is no combinational path from `wb_ready_i` or `x_valid_i`. A full queue shows ready low even in a cycle where it pops.
- **Queue:** each queue is a circular buffer with read/write pointers mod DEPTH and a count register of width clog2(DEPTH)+1. Push and pop in the same cycle leave the count unchanged.
- **Output register:** it is free when `!wb_valid_o || wb_ready_i`.
  - When free, the arbiter picks one non-empty queue head, loads it into the output register with `wb_src_o` set, and pops that queue.
  - If no queue is non-empty, `wb_valid_o` goes low.
- **Backpressure:** while `wb_valid_o && !wb_ready_i`, all wb_* outputs hold stable and no queue pops.
- **Round-robin:** `last_grant` resets to MUL. The search order starts at the source after `last_grant` and wraps ALU→LSU→MUL→ALU. `last_grant` updates only on a grant.
- **Flush:** on an edge with `flush_i` high, all counts, pointers and `wb_valid_o` are cleared. Pushes presented that cycle are dropped. `last_grant` is preserved.
- **Reset:** same as flush, plus `last_grant` is set to MUL.
- **Output reset values:** wb_valid_o=0, wb_value_o=0, wb_rob_idx_o=0, wb_src_o=0, pending_o=0. All *_ready_o go to 1 in the first cycle after reset deasserts.
- **Flush and reset priority:** if reset_i and flush_i are both high, reset wins. Flush has priority over push, pop and grant in the same cycle.

## Timing
- **Latency:** a result accepted in cycle c appears on wb_* in cycle c+2, given an empty queue, a free output register and no competing source.
- **Throughput:** one broadcast per cycle while `wb_ready_i` is high and any queue is non-empty.
- **Fairness:** with all three queues continuously non-empty, grants follow a strict ALU, LSU, MUL rotation. No source waits more than 2 grants.
- **pending_o:** registered; reflects the count after the current edge.
- **Accept/pop on one edge:** a result can be accepted on the same edge another entry is popped from that queue.

## Structure
- **Shared package `core_pkg`:**
  - DATA_W and ROB_IDX_W constants.
  - `fu_src_e` enum: SRC_ALU=0, SRC_LSU=1, SRC_MUL=2.
  - `wb_pkt_t` struct: value, rob_idx.
- **Sub-module `wb_fifo`:** parameterised by DEPTH. Ports: push, pkt, pop, head pkt, count/full/empty, flush. Instanced three times.
- **Top level:** arbiter, `last_grant` register and output register.

## Test plan
1. **Single push:** reset, then alu_valid_i=1 for one cycle with value 0xDEADBEEF, idx 5 and wb_ready_i=1. Expect wb_valid_o=1, value 0xDEADBEEF, idx 5, src 0 exactly two cycles later, then wb_valid_o=0.
2. **Three-way contention:** all three sources push in the same cycle with idx 1/2/3 and wb_ready_i=1. Expect broadcasts in consecutive cycles, order ALU(1), LSU(2), MUL(3).
3. **Backpressure:** wb_ready_i=0 with LSU pushing every cycle. Expect lsu_ready_o low after DEPTH+1 accepted pushes and wb_* held stable. Raising wb_ready_i then drains all entries in FIFO order.
4. **Round-robin carry-over:** last grant MUL, then only ALU and MUL non-empty. Expect ALU granted next, then MUL.
5. **Flush:** flush_i pulses with entries queued in all sources. Expect the next cycle to show wb_valid_o=0 and pending_o=3'b000, with a push during the flush cycle not broadcast.
6. **Reset mid-operation:** assert reset_i while wb_valid_o=1 and wb_ready_i=0. Expect all outputs at their reset values next cycle and the next arbitration starting with ALU.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types: result/index widths, functional-unit source encoding
// and the writeback packet carried through the arbiter queues.
package core_pkg;

    localparam int DATA_W    = 32;
    localparam int ROB_IDX_W = 5;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSU = 2'd1,
        SRC_MUL = 2'd2
    } fu_src_e;

    typedef struct packed {
        logic [DATA_W-1:0]    value;
        logic [ROB_IDX_W-1:0] rob_idx;
    } wb_pkt_t;

    // Round-robin successor: ALU -> LSU -> MUL -> ALU.
    function automatic fu_src_e next_src(fu_src_e s);
        case (s)
            SRC_ALU: return SRC_LSU;
            SRC_LSU: return SRC_MUL;
            default: return SRC_ALU;
        endcase
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: three functional-unit result sources plus the
// broadcast port. Handshake: a transfer happens on any edge where valid and
// ready are both high; a valid producer holds its payload until it transfers.
interface wb_arbiter_if;
    import core_pkg::*;

    logic                 alu_valid_i;
    logic [DATA_W-1:0]    alu_value_i;
    logic [ROB_IDX_W-1:0] alu_rob_idx_i;
    logic                 alu_ready_o;

    logic                 lsu_valid_i;
    logic [DATA_W-1:0]    lsu_value_i;
    logic [ROB_IDX_W-1:0] lsu_rob_idx_i;
    logic                 lsu_ready_o;

    logic                 mul_valid_i;
    logic [DATA_W-1:0]    mul_value_i;
    logic [ROB_IDX_W-1:0] mul_rob_idx_i;
    logic                 mul_ready_o;

    logic                 wb_valid_o;
    logic [DATA_W-1:0]    wb_value_o;
    logic [ROB_IDX_W-1:0] wb_rob_idx_o;
    logic [1:0]           wb_src_o;
    logic                 wb_ready_i;
    logic [2:0]           pending_o;

    modport master (
        output alu_valid_i, alu_value_i, alu_rob_idx_i,
        output lsu_valid_i, lsu_value_i, lsu_rob_idx_i,
        output mul_valid_i, mul_value_i, mul_rob_idx_i,
        output wb_ready_i,
        input  alu_ready_o, lsu_ready_o, mul_ready_o,
        input  wb_valid_o, wb_value_o, wb_rob_idx_o, wb_src_o, pending_o
    );

    modport slave (
        input  alu_valid_i, alu_value_i, alu_rob_idx_i,
        input  lsu_valid_i, lsu_value_i, lsu_rob_idx_i,
        input  mul_valid_i, mul_value_i, mul_rob_idx_i,
        input  wb_ready_i,
        output alu_ready_o, lsu_ready_o, mul_ready_o,
        output wb_valid_o, wb_value_o, wb_rob_idx_o, wb_src_o, pending_o
    );

endinterface

// File: rtl/wb_fifo.sv
// Per-source result queue: circular buffer with free-running pointers that
// wrap naturally because DEPTH is a power of two.
module wb_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  wb_pkt_t                pkt,
    input  logic                   pop,
    output wb_pkt_t                head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_pkt_t          mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pkt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: three per-unit result queues drained round-robin into a
// single registered broadcast bus feeding the ROB update port.
module wb_arbiter
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic         clk_i,
    input logic         reset_i,
    input logic         flush_i,
    wb_arbiter_if.slave bus
);

    wb_pkt_t              in_pkt [3];
    wb_pkt_t              head   [3];
    logic [$clog2(DEPTH):0] cnt  [3];
    logic [2:0]           valid_in;
    logic [2:0]           ready;
    logic [2:0]           push;
    logic [2:0]           pop;
    logic [2:0]           full;
    logic [2:0]           empty;

    logic                 wb_valid;
    logic [DATA_W-1:0]    wb_value;
    logic [ROB_IDX_W-1:0] wb_rob_idx;
    fu_src_e              wb_src;
    fu_src_e              last_grant;

    logic                 out_free;
    logic                 grant_found;
    fu_src_e              grant_src;
    fu_src_e              cand;

    assign in_pkt[0] = '{value: bus.alu_value_i, rob_idx: bus.alu_rob_idx_i};
    assign in_pkt[1] = '{value: bus.lsu_value_i, rob_idx: bus.lsu_rob_idx_i};
    assign in_pkt[2] = '{value: bus.mul_value_i, rob_idx: bus.mul_rob_idx_i};
    assign valid_in  = {bus.mul_valid_i, bus.lsu_valid_i, bus.alu_valid_i};

    // Ready comes from registered occupancy only, so a full queue stays
    // not-ready even on the edge it pops.
    assign ready = ~full & {3{~flush_i}};
    assign push  = valid_in & ready;

    for (genvar g = 0; g < 3; g++) begin : g_queue
        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk_i),
            .rst   (reset_i),
            .flush (flush_i),
            .push  (push[g]),
            .pkt   (in_pkt[g]),
            .pop   (pop[g]),
            .head  (head[g]),
            .count (cnt[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    assign out_free = !wb_valid || bus.wb_ready_i;

    always_comb begin
        grant_found = 1'b0;
        grant_src   = SRC_ALU;
        cand        = last_grant;
        for (int i = 0; i < 3; i++) begin
            cand = next_src(cand);
            if (!grant_found && !empty[cand]) begin
                grant_found = 1'b1;
                grant_src   = cand;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (out_free && grant_found && !flush_i) begin
            pop[grant_src] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wb_valid   <= 1'b0;
            wb_value   <= '0;
            wb_rob_idx <= '0;
            wb_src     <= SRC_ALU;
            last_grant <= SRC_MUL;
        end else if (flush_i) begin
            wb_valid <= 1'b0;
        end else if (out_free) begin
            if (grant_found) begin
                wb_valid   <= 1'b1;
                wb_value   <= head[grant_src].value;
                wb_rob_idx <= head[grant_src].rob_idx;
                wb_src     <= grant_src;
                last_grant <= grant_src;
            end else begin
                wb_valid <= 1'b0;
            end
        end
    end

    assign bus.alu_ready_o  = ready[0];
    assign bus.lsu_ready_o  = ready[1];
    assign bus.mul_ready_o  = ready[2];
    assign bus.wb_valid_o   = wb_valid;
    assign bus.wb_value_o   = wb_value;
    assign bus.wb_rob_idx_o = wb_rob_idx;
    assign bus.wb_src_o     = wb_src;
    assign bus.pending_o    = {cnt[2] != '0, cnt[1] != '0, cnt[0] != '0};

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_wb_arbiter;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] value;
        logic [4:0]  idx;
    } pkt_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [2:0]  v;
    logic [31:0] val [3];
    logic [4:0]  idx [3];
    logic        wb_ready;

    always #5 clk = ~clk;

    wb_arbiter_if bus ();

    assign bus.alu_valid_i   = v[0];
    assign bus.alu_value_i   = val[0];
    assign bus.alu_rob_idx_i = idx[0];
    assign bus.lsu_valid_i   = v[1];
    assign bus.lsu_value_i   = val[1];
    assign bus.lsu_rob_idx_i = idx[1];
    assign bus.mul_valid_i   = v[2];
    assign bus.mul_value_i   = val[2];
    assign bus.mul_rob_idx_i = idx[2];
    assign bus.wb_ready_i    = wb_ready;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .flush_i (flush),
        .bus     (bus)
    );

    // Reference model: one queue per source plus the broadcast register.
    pkt_t        q0 [$];
    pkt_t        q1 [$];
    pkt_t        q2 [$];
    logic        m_valid;
    logic [31:0] m_value;
    logic [4:0]  m_idx;
    logic [1:0]  m_src;
    int          m_last;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int qsize(int s);
        case (s)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(int s, pkt_t p);
        case (s)
            0:       q0.push_back(p);
            1:       q1.push_back(p);
            default: q2.push_back(p);
        endcase
    endtask

    task automatic qpop(int s, output pkt_t p);
        case (s)
            0:       p = q0.pop_front();
            1:       p = q1.pop_front();
            default: p = q2.pop_front();
        endcase
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete(); q2.delete();
        m_valid = 1'b0;
        m_value = '0;
        m_idx   = '0;
        m_src   = '0;
        m_last  = 2;
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [2:0] acc;
        int         g;
        int         s;
        pkt_t       p;
        if (reset) begin
            model_reset();
        end else if (flush) begin
            q0.delete(); q1.delete(); q2.delete();
            m_valid = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) acc[k] = v[k] && (qsize(k) < DEPTH);
            if (!m_valid || wb_ready) begin
                g = -1;
                for (int k = 1; k <= 3; k++) begin
                    s = (m_last + k) % 3;
                    if (g < 0 && qsize(s) > 0) g = s;
                end
                if (g >= 0) begin
                    qpop(g, p);
                    m_valid = 1'b1;
                    m_value = p.value;
                    m_idx   = p.idx;
                    m_src   = 2'(g);
                    m_last  = g;
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (acc[k]) qpush(k, '{value: val[k], idx: idx[k]});
            end
        end
    endtask

    task automatic cycle();
        #1;
        check("alu_ready", bus.alu_ready_o, (qsize(0) < DEPTH) && !flush);
        check("lsu_ready", bus.lsu_ready_o, (qsize(1) < DEPTH) && !flush);
        check("mul_ready", bus.mul_ready_o, (qsize(2) < DEPTH) && !flush);
        model_edge();
        @(posedge clk);
        #1;
        check("wb_valid", bus.wb_valid_o, m_valid);
        check("wb_value", bus.wb_value_o, m_value);
        check("wb_rob_idx", bus.wb_rob_idx_o, m_idx);
        check("wb_src", bus.wb_src_o, m_src);
        check("pending", bus.pending_o, {qsize(2) > 0, qsize(1) > 0, qsize(0) > 0});
    endtask

    task automatic set_push(logic [2:0] mask, logic [4:0] i0, logic [4:0] i1, logic [4:0] i2);
        v = mask;
        idx[0] = i0; idx[1] = i1; idx[2] = i2;
        for (int k = 0; k < 3; k++) val[k] = $urandom;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; wb_ready = 1'b1; v = '0;
        for (int k = 0; k < 3; k++) begin val[k] = '0; idx[k] = '0; end
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle();
        check("rst_valid", bus.wb_valid_o, 0);
        check("rst_pending", bus.pending_o, 0);
        reset = 1'b0;

        // Single push: visible exactly two edges after acceptance.
        v = 3'b001; val[0] = 32'hDEADBEEF; idx[0] = 5'd5;
        cycle();
        v = '0;
        check("t1_early", bus.wb_valid_o, 0);
        cycle();
        check("t1_valid", bus.wb_valid_o, 1);
        check("t1_value", bus.wb_value_o, 32'hDEADBEEF);
        check("t1_idx", bus.wb_rob_idx_o, 5);
        check("t1_src", bus.wb_src_o, 0);
        cycle();
        check("t1_drop", bus.wb_valid_o, 0);

        // Three-way contention from reset: ALU, LSU, MUL order.
        reset = 1'b1; cycle(); reset = 1'b0;
        set_push(3'b111, 5'd1, 5'd2, 5'd3);
        cycle();
        v = '0;
        cycle(); check("t2_g0", {bus.wb_src_o, bus.wb_rob_idx_o}, {2'd0, 5'd1});
        cycle(); check("t2_g1", {bus.wb_src_o, bus.wb_rob_idx_o}, {2'd1, 5'd2});
        cycle(); check("t2_g2", {bus.wb_src_o, bus.wb_rob_idx_o}, {2'd2, 5'd3});
        cycle(); check("t2_idle", bus.wb_valid_o, 0);

        // Backpressure on a single LSU stream, then drain in order.
        wb_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_push(3'b010, 5'd0, 5'(10 + i), 5'd0);
            cycle();
        end
        #1;
        check("t3_lsu_full", bus.lsu_ready_o, 0);
        v = '0; wb_ready = 1'b1;
        repeat (4) cycle();
        check("t3_drained", bus.wb_valid_o, 0);

        // Round-robin carry-over after a MUL grant.
        reset = 1'b1; cycle(); reset = 1'b0;
        set_push(3'b100, 5'd0, 5'd0, 5'd7);
        cycle(); v = '0;
        cycle(); check("t4_mul_first", bus.wb_src_o, 2);
        set_push(3'b101, 5'd8, 5'd0, 5'd9);
        cycle(); v = '0;
        cycle(); check("t4_alu_next", bus.wb_src_o, 0);
        cycle(); check("t4_mul_last", bus.wb_src_o, 2);

        // Flush with entries queued everywhere; flush-cycle pushes dropped.
        wb_ready = 1'b0;
        set_push(3'b111, 5'd11, 5'd12, 5'd13); cycle();
        set_push(3'b111, 5'd14, 5'd15, 5'd16); cycle();
        flush = 1'b1;
        set_push(3'b111, 5'd17, 5'd18, 5'd19); cycle();
        flush = 1'b0; v = '0;
        check("t5_valid", bus.wb_valid_o, 0);
        check("t5_pending", bus.pending_o, 0);
        wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t5_quiet", bus.wb_valid_o, 0);
        end

        // Reset while a broadcast is stalled.
        wb_ready = 1'b0;
        set_push(3'b111, 5'd21, 5'd22, 5'd23); cycle();
        v = '0; cycle();
        check("t6_stalled", bus.wb_valid_o, 1);
        reset = 1'b1; cycle(); reset = 1'b0;
        check("t6_outputs", {bus.wb_valid_o, bus.wb_value_o, bus.wb_rob_idx_o, bus.wb_src_o, bus.pending_o}, '0);
        wb_ready = 1'b1;
        set_push(3'b111, 5'd24, 5'd25, 5'd26); cycle();
        v = '0; cycle();
        check("t6_alu_first", bus.wb_src_o, 0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            v = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) begin
                val[k] = $urandom;
                idx[k] = 5'($urandom_range(0, 31));
            end
            wb_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 39) == 0);
            reset    = ($urandom_range(0, 149) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
